mf8_reg_wr: RTL and testbench

Write-port sequencer for the mf8 core's 32 x 8 register file. It accepts byte and register-pair (16-bit) write requests from the execute stage, plus an optional debug write port, and drives the file's address, write-enable and write-data pins. It meets the file's one-cycle address-ahead write protocol and overlaps consecutive writes so that sustained throughput is one byte per cycle.

---
 rtl/mf8_pkg.sv | 14 +
 rtl/mf8_reg_wr.sv | 97 +++++++++
 tb/tb_mf8_reg_wr.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mf8_pkg.sv
// Shared types and constants for the mf8 register-file write sequencer.
package mf8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wr_state_e;

  // Z pointer pair; a pair write aimed at either half lands on both.
  localparam logic [4:0] REG_ZL = 5'd30;
  localparam logic [4:0] REG_ZH = 5'd31;

endpackage

// File: rtl/mf8_reg_wr.sv
// Write-port sequencer for the mf8 32x8 register file (address one cycle ahead of write).
// Optional debug byte-write port enabled by defining MF8_DBG_PORT_EN.
module mf8_reg_wr
  import mf8_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Pair,
  input  logic [4:0]  Addr,
  input  logic [15:0] Data,
  output logic        Ready,
  input  logic [4:0]  Rd_Sel,
  input  logic        Dbg_Req,
  input  logic [4:0]  Dbg_Addr,
  input  logic [7:0]  Dbg_Data,
  output logic        Dbg_Ack,
  output logic [4:0]  Rf_Addr,
  output logic        Rf_Wr,
  output logic [7:0]  Rf_Data,
  output logic        Busy
);

  wr_state_e   state_p0;
  logic        cap_pair_p0;
  logic [4:0]  cap_addr_p0;
  logic [15:0] cap_data_p0;

  logic        last_wr;
  logic        ready_i;
  logic        core_acc;
  logic        dbg_acc;
  logic [4:0]  core_tgt;

  assign core_tgt = {Addr[4:1], Addr[0] & ~Pair};
  assign last_wr  = (state_p0 == WR_HI) || ((state_p0 == WR_LO) && !cap_pair_p0);
  assign ready_i  = (state_p0 == IDLE) || last_wr;
  assign core_acc = Req && ready_i;

`ifdef MF8_DBG_PORT_EN
  // Core request always wins a shared slot; debug waits for a free one.
  assign dbg_acc = Dbg_Req && ready_i && !Req;
`else
  logic dbg_unused;
  assign dbg_acc    = 1'b0;
  assign dbg_unused = ^{Dbg_Req, Dbg_Addr, Dbg_Data};
`endif

  // Address stage: next write target is presented while the current write completes.
  always_comb begin
    Rf_Addr = Rd_Sel;
    if (core_acc) begin
      Rf_Addr = core_tgt;
`ifdef MF8_DBG_PORT_EN
    end else if (dbg_acc) begin
      Rf_Addr = Dbg_Addr;
`endif
    end else if ((state_p0 == WR_LO) && cap_pair_p0) begin
      Rf_Addr = {cap_addr_p0[4:1], 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_p0    <= IDLE;
      cap_pair_p0 <= 1'b0;
      cap_addr_p0 <= 5'd0;
      cap_data_p0 <= 16'd0;
    end else begin
      if (core_acc) begin
        state_p0    <= WR_LO;
        cap_pair_p0 <= Pair;
        cap_addr_p0 <= core_tgt;
        cap_data_p0 <= Data;
`ifdef MF8_DBG_PORT_EN
      end else if (dbg_acc) begin
        state_p0    <= WR_LO;
        cap_pair_p0 <= 1'b0;
        cap_addr_p0 <= Dbg_Addr;
        cap_data_p0 <= {8'h00, Dbg_Data};
`endif
      end else if ((state_p0 == WR_LO) && cap_pair_p0) begin
        state_p0 <= WR_HI;
      end else begin
        state_p0 <= IDLE;
      end
    end
  end

  // Write stage: enable and data follow the registered state, so reset drops them at once.
  assign Rf_Wr   = (state_p0 != IDLE);
  assign Busy    = (state_p0 != IDLE);
  assign Ready   = ready_i;
  assign Rf_Data = (state_p0 == WR_HI) ? cap_data_p0[15:8] : cap_data_p0[7:0];
  assign Dbg_Ack = dbg_acc;

endmodule

// File: tb/tb_mf8_reg_wr.sv
// Scoreboard bench for mf8_reg_wr: directed writes, file writes checked by a monitor.
module tb_mf8_reg_wr;
  import mf8_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        Pair;
  logic [4:0]  Addr;
  logic [15:0] Data;
  logic        Ready;
  logic [4:0]  Rd_Sel;
  logic        Dbg_Req;
  logic [4:0]  Dbg_Addr;
  logic [7:0]  Dbg_Data;
  logic        Dbg_Ack;
  logic [4:0]  Rf_Addr;
  logic        Rf_Wr;
  logic [7:0]  Rf_Data;
  logic        Busy;

  mf8_reg_wr dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Pair(Pair), .Addr(Addr), .Data(Data),
    .Ready(Ready), .Rd_Sel(Rd_Sel), .Dbg_Req(Dbg_Req), .Dbg_Addr(Dbg_Addr),
    .Dbg_Data(Dbg_Data), .Dbg_Ack(Dbg_Ack), .Rf_Addr(Rf_Addr), .Rf_Wr(Rf_Wr),
    .Rf_Data(Rf_Data), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [12:0] sb[$];
  logic [4:0]  lat_addr = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  task automatic next_drive();
    @(posedge Clk);
    #1;
  endtask

  // Models the file: a write lands on the address latched at the previous edge.
  always @(negedge Clk) begin
    logic [12:0] exp;
    if (Rf_Wr === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_spurious: write r%0d=0x%02h, none expected", lat_addr, Rf_Data);
      end else begin
        exp = sb.pop_front();
        chk("sb_write{addr,data}", {19'd0, lat_addr, Rf_Data}, {19'd0, exp});
      end
    end
    lat_addr = Rf_Addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Req = 1'b0; Pair = 1'b0; Addr = 5'd0; Data = 16'd0;
    Rd_Sel = 5'd7; Dbg_Req = 1'b0; Dbg_Addr = 5'd0; Dbg_Data = 8'd0;
    repeat (2) next_drive();
    Reset = 1'b1;

    // Reset state
    @(negedge Clk);
    chk("rst_rf_addr", Rf_Addr, 5'd7);
    chk("rst_rf_wr", Rf_Wr, 1'b0);
    chk("rst_ready", Ready, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_rf_data", Rf_Data, 8'h00);
    chk("rst_dbg_ack", Dbg_Ack, 1'b0);

    // Byte write r5 = 0xA5
    next_drive();
    Req = 1'b1; Pair = 1'b0; Addr = 5'd5; Data = 16'h00A5;
    push_wr(5'd5, 8'hA5);
    @(negedge Clk);
    chk("byte_acc_addr", Rf_Addr, 5'd5);
    next_drive();
    Req = 1'b0;
    @(negedge Clk);
    chk("byte_wr_busy", Busy, 1'b1);
    chk("byte_wr_rdsel", Rf_Addr, 5'd7);
    chk("byte_wr_ready", Ready, 1'b1);
    next_drive();
    @(negedge Clk);
    chk("byte_idle_busy", Busy, 1'b0);

    // Pair write aimed at r31 lands on r30 then r31
    next_drive();
    Req = 1'b1; Pair = 1'b1; Addr = REG_ZH; Data = 16'h1234;
    push_wr(REG_ZL, 8'h34);
    push_wr(REG_ZH, 8'h12);
    @(negedge Clk);
    chk("pair_acc_addr", Rf_Addr, REG_ZL);
    next_drive();
    Req = 1'b0;
    @(negedge Clk);
    chk("pair_lo_ready", Ready, 1'b0);
    chk("pair_lo_addr", Rf_Addr, REG_ZH);
    chk("pair_lo_data", Rf_Data, 8'h34);
    next_drive();
    @(negedge Clk);
    chk("pair_hi_ready", Ready, 1'b1);
    chk("pair_hi_data", Rf_Data, 8'h12);
    next_drive();
    @(negedge Clk);
    chk("pair_idle_wr", Rf_Wr, 1'b0);

    // Three back-to-back bytes
    for (int i = 1; i <= 3; i++) begin
      next_drive();
      Req = 1'b1; Pair = 1'b0; Addr = 5'(i); Data = 16'(8'(i * 8'h11));
      push_wr(5'(i), 8'(i * 8'h11));
      @(negedge Clk);
      chk("b2b_ready", Ready, 1'b1);
      chk("b2b_addr", Rf_Addr, 32'(i));
      if (i > 1) chk("b2b_wr_cont", Rf_Wr, 1'b1);
    end
    next_drive();
    Req = 1'b0;
    @(negedge Clk);
    chk("b2b_last_wr", Rf_Wr, 1'b1);
    chk("b2b_last_data", Rf_Data, 8'h33);
    next_drive();

    // Byte request held across a pair write is taken only in WR_HI
    next_drive();
    Req = 1'b1; Pair = 1'b1; Addr = 5'd10; Data = 16'hBBAA;
    push_wr(5'd10, 8'hAA);
    push_wr(5'd11, 8'hBB);
    push_wr(5'd4, 8'h44);
    next_drive();
    Pair = 1'b0; Addr = 5'd4; Data = 16'h0044;
    @(negedge Clk);
    chk("hold_lo_ready", Ready, 1'b0);
    chk("hold_lo_addr", Rf_Addr, 5'd11);
    next_drive();
    @(negedge Clk);
    chk("hold_hi_addr", Rf_Addr, 5'd4);
    next_drive();
    Req = 1'b0;
    repeat (2) next_drive();

    // Core and debug together: core first, debug afterwards if built
    Req = 1'b1; Pair = 1'b0; Addr = 5'd8; Data = 16'h0088;
    Dbg_Req = 1'b1; Dbg_Addr = 5'd9; Dbg_Data = 8'h99;
    push_wr(5'd8, 8'h88);
    @(negedge Clk);
    chk("dbg_core_first_ack", Dbg_Ack, 1'b0);
    chk("dbg_core_first_addr", Rf_Addr, 5'd8);
    next_drive();
    Req = 1'b0;
    @(negedge Clk);
`ifdef MF8_DBG_PORT_EN
    push_wr(5'd9, 8'h99);
    chk("dbg_ack", Dbg_Ack, 1'b1);
    chk("dbg_addr", Rf_Addr, 5'd9);
`else
    chk("dbg_ack_off", Dbg_Ack, 1'b0);
    chk("dbg_addr_off", Rf_Addr, 5'd7);
`endif
    next_drive();
    Dbg_Req = 1'b0;
    @(negedge Clk);
    chk("dbg_ack_drop", Dbg_Ack, 1'b0);
    repeat (2) next_drive();

    // Reset during WR_LO of a pair aborts both bytes
    Req = 1'b1; Pair = 1'b1; Addr = 5'd20; Data = 16'h5566;
    @(negedge Clk);
    chk("abort_acc_addr", Rf_Addr, 5'd20);
    next_drive();
    Req = 1'b0;
    Reset = 1'b0;
    #1;
    chk("abort_wr_async", Rf_Wr, 1'b0);
    chk("abort_busy", Busy, 1'b0);
    @(negedge Clk);
    chk("abort_wr_neg", Rf_Wr, 1'b0);
    next_drive();
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_idle_ready", Ready, 1'b1);
    chk("abort_idle_wr", Rf_Wr, 1'b0);
    next_drive();
    @(negedge Clk);
    chk("abort_idle_busy", Busy, 1'b0);

    repeat (3) next_drive();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
